// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port.
// Registers one accepted writeback per cycle and flags RAW hazards.
module regfile_wb_arbiter #(
   parameter int NREQ  = 3,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*5-1:0]  req_addr,
   input  logic [NREQ*32-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               wr_en,
   output logic [4:0]         wr_addr,
   output logic [31:0]        wr_data,
   input  logic [4:0]         rd_addr1,
   input  logic [4:0]         rd_addr2,
   output logic               hazard1,
   output logic               hazard2,
   output logic [CNT_W-1:0]   wr_count
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_en_q, wr_en_d;
   logic [4:0]       wr_addr_q, wr_addr_d;
   logic [31:0]      wr_data_q, wr_data_d;

   logic             any_valid;
   logic             grant;
   logic [PTR_W-1:0] gnt_idx;
   logic [4:0]       sel_addr;
   logic [31:0]      sel_data;
   logic             hit1, hit2;

   function automatic logic [PTR_W-1:0] rr_idx(
      input logic [PTR_W-1:0] p,
      input int               k
   );
      int s;
      s = int'(p) + k;
      if (s >= NREQ) s = s - NREQ;
      return PTR_W'(s);
   endfunction

   // first valid requester at or after the pointer, wrapping around
   always_comb begin
      any_valid = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any_valid && req_valid[rr_idx(rr_ptr_q, k)]) begin
            any_valid = 1'b1;
            gnt_idx   = rr_idx(rr_ptr_q, k);
         end
      end
   end

   assign grant = any_valid & ~freeze & ~rst;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == PTR_W'(i)) begin
            sel_addr = req_addr[i*5 +: 5];
            sel_data = req_data[i*32 +: 32];
         end
      end
   end

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (grant) begin
         rr_ptr_d  = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);
         cnt_d     = cnt_q + CNT_W'(1);
         wr_en_d   = (sel_addr != 5'd0);
         wr_addr_d = sel_addr;
         wr_data_d = sel_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // $zero never hazards; pending requests and the in-flight write do
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_addr[i*5 +: 5] == rd_addr1) hit1 = 1'b1;
         if (req_valid[i] && req_addr[i*5 +: 5] == rd_addr2) hit2 = 1'b1;
      end
      if (wr_en_q && wr_addr_q == rd_addr1) hit1 = 1'b1;
      if (wr_en_q && wr_addr_q == rd_addr2) hit2 = 1'b1;
   end

   assign hazard1  = hit1 & (rd_addr1 != 5'd0);
   assign hazard2  = hit2 & (rd_addr2 != 5'd0);
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign wr_count = cnt_q;

endmodule
